schmidl_cox_ctrl: RTL and testbench

Run-control sequencer for the Schmidl & Cox preamble synchronizer.
- On a start command it programs the synchronizer's six setting registers over its setting bus, then pulses `clear`.
- It gates the sample stream into the synchronizer and tracks `sof`/`eof`.
- It enforces a post-frame holdoff and a search timeout, and reports frame count and status.
- It sits between the host control registers/radio RX stream and the synchronizer instance.

---
 rtl/schmidl_cox_ctrl_pkg.sv | 44 ++++
 rtl/schmidl_cox_ctrl_setting_bus_seq.sv | 63 ++++++
 rtl/schmidl_cox_ctrl.sv | 168 ++++++++++++++++
 tb/tb_schmidl_cox_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_ctrl_pkg.sv
// Shared definitions for the Schmidl & Cox run-control sequencer: state
// encodings, synchronizer setting addresses and the CONFIG write order.
package schmidl_cox_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONFIG  = 3'd1,
    S_CLEAR   = 3'd2,
    S_SEARCH  = 3'd3,
    S_FRAME   = 3'd4,
    S_HOLDOFF = 3'd5
  } state_e;

  localparam logic [7:0] SR_FRAME_LEN            = 8'd0;
  localparam logic [7:0] SR_GAP_LEN              = 8'd1;
  localparam logic [7:0] SR_OFFSET               = 8'd2;
  localparam logic [7:0] SR_NUMBER_SYMBOLS_MAX   = 8'd3;
  localparam logic [7:0] SR_NUMBER_SYMBOLS_SHORT = 8'd4;
  localparam logic [7:0] SR_THRESHOLD            = 8'd5;

  localparam int NUM_WRITES = 6;

  // Write-order indices: threshold goes first so detection is never armed
  // with a stale threshold.
  localparam logic [2:0] WR_THRESHOLD = 3'd0;
  localparam logic [2:0] WR_FRAME_LEN = 3'd1;
  localparam logic [2:0] WR_GAP_LEN   = 3'd2;
  localparam logic [2:0] WR_OFFSET    = 3'd3;
  localparam logic [2:0] WR_SYM_MAX   = 3'd4;
  localparam logic [2:0] WR_SYM_SHORT = 3'd5;

  function automatic logic [7:0] wr_addr(input logic [2:0] idx);
    case (idx)
      WR_THRESHOLD: wr_addr = SR_THRESHOLD;
      WR_FRAME_LEN: wr_addr = SR_FRAME_LEN;
      WR_GAP_LEN:   wr_addr = SR_GAP_LEN;
      WR_OFFSET:    wr_addr = SR_OFFSET;
      WR_SYM_MAX:   wr_addr = SR_NUMBER_SYMBOLS_MAX;
      WR_SYM_SHORT: wr_addr = SR_NUMBER_SYMBOLS_SHORT;
      default:      wr_addr = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/schmidl_cox_ctrl_setting_bus_seq.sv
// Six-entry setting-bus walker: on go it snapshots the values and issues one
// write per cycle in write-order; kill drops the strobe immediately.
module setting_bus_seq
  import schmidl_cox_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        go,
  input  logic                        kill,
  input  logic [NUM_WRITES-1:0][15:0] cfg_vals,
  output logic                        set_stb,
  output logic [7:0]                  set_addr,
  output logic [31:0]                 set_data,
  output logic                        busy,
  output logic                        last
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_WRITES - 1);

  logic [NUM_WRITES-1:0][15:0] vals_q;
  logic [2:0]                  idx_q;
  logic [2:0]                  idx_nxt;
  logic                        stb_q;

  assign idx_nxt = idx_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vals_q   <= '0;
      idx_q    <= '0;
      stb_q    <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
    end else if (kill) begin
      idx_q    <= '0;
      stb_q    <= 1'b0;
      set_addr <= '0;
      set_data <= '0;
    end else if (go) begin
      // First write comes straight from the inputs so it lands the cycle after go.
      vals_q   <= cfg_vals;
      idx_q    <= '0;
      stb_q    <= 1'b1;
      set_addr <= wr_addr(3'd0);
      set_data <= {16'd0, cfg_vals[0]};
    end else if (stb_q) begin
      if (idx_q == LAST_IDX) begin
        stb_q    <= 1'b0;
        set_addr <= '0;
        set_data <= '0;
      end else begin
        idx_q    <= idx_nxt;
        set_addr <= wr_addr(idx_nxt);
        set_data <= {16'd0, vals_q[idx_nxt]};
      end
    end
  end

  assign set_stb = stb_q & ~kill;
  assign busy    = stb_q;
  assign last    = stb_q & (idx_q == LAST_IDX);

endmodule

// File: rtl/schmidl_cox_ctrl.sv
// Run-control sequencer for the Schmidl & Cox synchronizer: programs its
// settings, gates the sample stream and tracks frames, holdoff and timeout.
module schmidl_cox_ctrl
  import schmidl_cox_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_frame_len,
  input  logic [15:0] cfg_gap_len,
  input  logic [15:0] cfg_offset,
  input  logic [15:0] cfg_num_symbols_max,
  input  logic [15:0] cfg_num_symbols_short,
  input  logic [15:0] cfg_threshold,
  input  logic [15:0] cfg_holdoff,
  input  logic [23:0] cfg_timeout,
  input  logic        cfg_continuous,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        sc_set_stb,
  output logic [7:0]  sc_set_addr,
  output logic [31:0] sc_set_data,
  output logic        sc_clear,
  input  logic        sof,
  input  logic        eof,
  output logic        busy,
  output logic [2:0]  state,
  output logic [15:0] frame_count,
  output logic        timeout_flag,
  output logic        done
);

  state_e      state_q, state_nxt;
  logic [15:0] holdoff_q;
  logic [23:0] timeout_q;
  logic        cont_q;
  logic [23:0] tmo_cnt;
  logic [15:0] hold_cnt;
  logic        clear_q;

  logic        accept, abort_hit, frame_inc, tmo_set, done_nxt;
  logic        seq_busy, seq_last, pass_en;
  state_e      exit_state;
  logic        exit_done;

  assign abort_hit = abort && (state_q != S_IDLE);
  assign accept    = (state_q == S_IDLE) && start && !abort;

  setting_bus_seq u_seq (
    .clk      (clk),
    .aresetn  (aresetn),
    .go       (accept),
    .kill     (abort_hit),
    .cfg_vals ({cfg_num_symbols_short, cfg_num_symbols_max, cfg_offset,
                cfg_gap_len, cfg_frame_len, cfg_threshold}),
    .set_stb  (sc_set_stb),
    .set_addr (sc_set_addr),
    .set_data (sc_set_data),
    .busy     (seq_busy),
    .last     (seq_last)
  );

  // Where a completed frame leads, shared by FRAME and the sof+eof SEARCH case.
  always_comb begin
    exit_done  = 1'b0;
    exit_state = S_HOLDOFF;
    if (holdoff_q == 16'd0) begin
      exit_state = cont_q ? S_SEARCH : S_IDLE;
      exit_done  = !cont_q;
    end
  end

  always_comb begin
    state_nxt = state_q;
    done_nxt  = 1'b0;
    frame_inc = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      S_IDLE:   if (accept) state_nxt = S_CONFIG;
      S_CONFIG: if (seq_last || !seq_busy) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = S_SEARCH;
      S_SEARCH: begin
        if (sof) begin
          if (eof) begin
            frame_inc = 1'b1;
            state_nxt = exit_state;
            done_nxt  = exit_done;
          end else begin
            state_nxt = S_FRAME;
          end
        end else if (timeout_q != 24'd0 && tmo_cnt == timeout_q - 24'd1) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FRAME: begin
        if (eof) begin
          frame_inc = 1'b1;
          state_nxt = exit_state;
          done_nxt  = exit_done;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt == holdoff_q - 16'd1) begin
          state_nxt = cont_q ? S_SEARCH : S_IDLE;
          done_nxt  = !cont_q;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
      frame_inc = 1'b0;
      tmo_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      holdoff_q    <= '0;
      timeout_q    <= '0;
      cont_q       <= 1'b0;
      tmo_cnt      <= '0;
      hold_cnt     <= '0;
      clear_q      <= 1'b0;
      frame_count  <= '0;
      timeout_flag <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      done     <= done_nxt;
      clear_q  <= (state_nxt == S_CLEAR);
      // Re-entering SEARCH after a same-cycle sof/eof restarts the search window.
      tmo_cnt  <= (state_q != S_SEARCH || frame_inc) ? 24'd0 : tmo_cnt + 24'd1;
      hold_cnt <= (state_q == S_HOLDOFF) ? hold_cnt + 16'd1 : 16'd0;
      if (accept) begin
        holdoff_q    <= cfg_holdoff;
        timeout_q    <= cfg_timeout;
        cont_q       <= cfg_continuous;
        frame_count  <= '0;
        timeout_flag <= 1'b0;
      end
      if (frame_inc) frame_count <= frame_count + 16'd1;
      if (tmo_set)   timeout_flag <= 1'b1;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;
  assign sc_clear = clear_q | abort_hit;

  // Zero-latency stream gate: drained in IDLE, stalled while configuring.
  assign pass_en  = (state_q == S_SEARCH) || (state_q == S_FRAME) || (state_q == S_HOLDOFF);
  assign o_tdata  = i_tdata;
  assign o_tlast  = i_tlast;
  assign o_tvalid = pass_en & i_tvalid;
  assign i_tready = (state_q == S_IDLE) | (pass_en & o_tready);

endmodule

// File: tb/tb_schmidl_cox_ctrl.sv
// Directed + randomized bench for schmidl_cox_ctrl with a cycle-accurate
// expectation built from the documented run-control timing.
module tb_schmidl_cox_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        start, abort;
  logic [15:0] cfg_frame_len, cfg_gap_len, cfg_offset, cfg_num_symbols_max;
  logic [15:0] cfg_num_symbols_short, cfg_threshold, cfg_holdoff;
  logic [23:0] cfg_timeout;
  logic        cfg_continuous;
  logic [31:0] i_tdata;
  logic        i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast, o_tvalid, o_tready;
  logic        sc_set_stb;
  logic [7:0]  sc_set_addr;
  logic [31:0] sc_set_data;
  logic        sc_clear, sof, eof, busy;
  logic [2:0]  state;
  logic [15:0] frame_count;
  logic        timeout_flag, done;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;
  int n;

  schmidl_cox_ctrl dut (
    .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_frame_len(cfg_frame_len), .cfg_gap_len(cfg_gap_len), .cfg_offset(cfg_offset),
    .cfg_num_symbols_max(cfg_num_symbols_max), .cfg_num_symbols_short(cfg_num_symbols_short),
    .cfg_threshold(cfg_threshold), .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout),
    .cfg_continuous(cfg_continuous),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .sc_set_stb(sc_set_stb), .sc_set_addr(sc_set_addr), .sc_set_data(sc_set_data),
    .sc_clear(sc_clear), .sof(sof), .eof(eof), .busy(busy), .state(state),
    .frame_count(frame_count), .timeout_flag(timeout_flag), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cfg();
    cfg_frame_len         = 16'($urandom);
    cfg_gap_len           = 16'($urandom);
    cfg_offset            = 16'($urandom);
    cfg_num_symbols_max   = 16'($urandom);
    cfg_num_symbols_short = 16'($urandom);
    cfg_threshold         = 16'($urandom);
    cfg_holdoff           = 16'($urandom);
    cfg_timeout           = 24'($urandom);
    cfg_continuous        = 1'($urandom);
  endtask

  // Issue start, then verify the six writes, the clear pulse and SEARCH entry.
  task automatic do_start(input logic [15:0] thr, input logic [15:0] fl, input logic [15:0] hold,
                          input logic [23:0] tmo, input logic cont);
    logic [15:0] ev [6];
    logic [7:0]  ea [6];
    ea = '{8'd5, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    ev[0] = thr; ev[1] = fl;
    ev[2] = 16'($urandom); ev[3] = 16'($urandom);
    ev[4] = 16'($urandom); ev[5] = 16'($urandom);
    cfg_threshold = ev[0]; cfg_frame_len = ev[1]; cfg_gap_len = ev[2];
    cfg_offset = ev[3]; cfg_num_symbols_max = ev[4]; cfg_num_symbols_short = ev[5];
    cfg_holdoff = hold; cfg_timeout = tmo; cfg_continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_cfg();
    i_tvalid = 1'b1;
    o_tready = 1'b1;
    exp_fc = 0;
    chk("start_fc_clr", 32'(frame_count), 0);
    chk("start_tflag_clr", 32'(timeout_flag), 0);
    for (int k = 0; k < 6; k++) begin
      chk("cfg_state", 32'(state), 1);
      chk("cfg_busy", 32'(busy), 1);
      chk("cfg_stb", 32'(sc_set_stb), 1);
      chk("cfg_addr", 32'(sc_set_addr), 32'(ea[k]));
      chk("cfg_data", sc_set_data, {16'd0, ev[k]});
      chk("cfg_itready", 32'(i_tready), 0);
      chk("cfg_otvalid", 32'(o_tvalid), 0);
      tick();
    end
    chk("clr_pulse", 32'(sc_clear), 1);
    chk("clr_state", 32'(state), 2);
    chk("clr_stb", 32'(sc_set_stb), 0);
    chk("clr_itready", 32'(i_tready), 0);
    tick();
    chk("search_state", 32'(state), 3);
    chk("search_clr_low", 32'(sc_clear), 0);
  endtask

  // From SEARCH: sof, gap cycles of FRAME, eof, then holdoff and exit.
  task automatic run_frame(input int gap, input int hold, input logic cont);
    int h;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("sof_to_frame", 32'(state), 4);
    repeat (gap) tick();
    chk("frame_stay", 32'(state), 4);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    exp_fc++;
    chk("eof_fc", 32'(frame_count), 32'(exp_fc));
    if (hold != 0) begin
      chk("holdoff_enter", 32'(state), 5);
      h = 0;
      while (state == 3'd5 && h < 2000) begin
        sof = 1'($urandom);
        eof = 1'($urandom);
        h++;
        tick();
      end
      sof = 1'b0;
      eof = 1'b0;
      chk("holdoff_len", 32'(h), 32'(hold));
      chk("holdoff_ignores_eof", 32'(frame_count), 32'(exp_fc));
    end
    chk("frame_exit_state", 32'(state), cont ? 32'd3 : 32'd0);
    chk("frame_exit_done", 32'(done), cont ? 32'd0 : 32'd1);
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; sof = 1'b0; eof = 1'b0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b1; o_tready = 1'b0;
    scramble_cfg();
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_stb", 32'(sc_set_stb), 0);
    chk("rst_addr", 32'(sc_set_addr), 0);
    chk("rst_data", sc_set_data, 0);
    chk("rst_clear", 32'(sc_clear), 0);
    chk("rst_fc", 32'(frame_count), 0);
    chk("rst_tflag", 32'(timeout_flag), 0);
    chk("rst_done", 32'(done), 0);
    chk("idle_otvalid", 32'(o_tvalid), 0);
    chk("idle_itready", 32'(i_tready), 1);
    aresetn = 1'b1;
    tick();

    // Continuous run, holdoff 10, three frames of 500 cycles.
    do_start(16'h2000, 16'd80, 16'd10, 24'd0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      i_tdata = $urandom; i_tlast = 1'($urandom); i_tvalid = 1'($urandom); o_tready = 1'($urandom);
      #1;
      chk("pass_data", o_tdata, i_tdata);
      chk("pass_last", 32'(o_tlast), 32'(i_tlast));
      chk("pass_valid", 32'(o_tvalid), 32'(i_tvalid));
      chk("pass_ready", 32'(i_tready), 32'(o_tready));
    end
    o_tready = 1'b0;
    #1;
    chk("search_stall", 32'(i_tready), 0);
    for (int f = 0; f < 3; f++) begin
      run_frame(500, 10, 1'b1);
      chk("cont_busy", 32'(busy), 1);
    end
    chk("cont_fc3", 32'(frame_count), 3);
    abort = 1'b1;
    #1;
    chk("abort_clear", 32'(sc_clear), 1);
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(state), 0);
    chk("abort_no_done", 32'(done), 0);
    chk("abort_fc_held", 32'(frame_count), 3);

    // Single shot, no holdoff.
    do_start(16'($urandom), 16'($urandom), 16'd0, 24'd0, 1'b0);
    run_frame(int'($urandom_range(1, 40)), 0, 1'b0);
    chk("single_fc", 32'(frame_count), 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);

    // sof and eof together in SEARCH.
    do_start(16'($urandom), 16'($urandom), 16'd0, 24'd0, 1'b0);
    sof = 1'b1; eof = 1'b1;
    tick();
    sof = 1'b0; eof = 1'b0;
    chk("sofeof_state", 32'(state), 0);
    chk("sofeof_done", 32'(done), 1);
    chk("sofeof_fc", 32'(frame_count), 1);

    // Search timeout of 100 cycles.
    do_start(16'($urandom), 16'($urandom), 16'd0, 24'd100, 1'b0);
    n = 0;
    while (state == 3'd3 && n < 1000) begin
      n++;
      tick();
    end
    chk("timeout_len", 32'(n), 100);
    chk("timeout_idle", 32'(state), 0);
    chk("timeout_flag", 32'(timeout_flag), 1);
    chk("timeout_no_done", 32'(done), 0);

    // sof on the last SEARCH cycle beats the timeout.
    do_start(16'($urandom), 16'($urandom), 16'd0, 24'd100, 1'b0);
    repeat (99) tick();
    chk("last_search", 32'(state), 3);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("sof_beats_tmo", 32'(state), 4);
    chk("sof_beats_tflag", 32'(timeout_flag), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_frame_idle", 32'(state), 0);

    // Abort on the third CONFIG write.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("third_addr", 32'(sc_set_addr), 1);
    abort = 1'b1;
    #1;
    chk("abort_cfg_stb", 32'(sc_set_stb), 0);
    chk("abort_cfg_clear", 32'(sc_clear), 1);
    tick();
    abort = 1'b0;
    chk("abort_cfg_idle", 32'(state), 0);
    chk("abort_cfg_stb_after", 32'(sc_set_stb), 0);
    chk("abort_cfg_done", 32'(done), 0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(state), 0);
    chk("start_abort_nostb", 32'(sc_set_stb), 0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      int hold;
      logic cont;
      hold = int'($urandom_range(1, 8));
      cont = 1'($urandom);
      do_start(16'($urandom), 16'($urandom), 16'(hold), 24'd0, cont);
      run_frame(int'($urandom_range(0, 30)), hold, cont);
      if (cont) begin
        run_frame(int'($urandom_range(0, 30)), hold, cont);
        chk("rand_fc", 32'(frame_count), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
      end
      chk("rand_end_idle", 32'(state), 0);
    end

    // Reset mid-run.
    do_start(16'($urandom), 16'($urandom), 16'd0, 24'd0, 1'b1);
    aresetn = 1'b0;
    tick();
    chk("midrst_state", 32'(state), 0);
    chk("midrst_clear", 32'(sc_clear), 0);
    aresetn = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
